// File: rtl/bpu_btb.sv
// Fully-associative branch target buffer with 2-bit direction counters.
// Two lookup ports per fetch pair, one resolution update port, round-robin replacement.
`timescale 1ns/1ps
module bpu_btb #(
   parameter int         ENTRIES  = 8,
   parameter logic [1:0] CNT_INIT = 2'b10
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] current_pc1,
   input  logic [31:0] current_pc2,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        flush_all,
   output logic [32:0] bp_bus,
   output logic        next_inst_invalid,
   output logic        hit_any
);

   localparam int IW = $clog2(ENTRIES);

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [31:0]        tag_q    [ENTRIES];
   logic [31:0]        tag_d    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [31:0]        target_d [ENTRIES];
   logic [1:0]         cnt_q    [ENTRIES];
   logic [1:0]         cnt_d    [ENTRIES];
   logic [IW-1:0]      rr_q, rr_d;

   logic [ENTRIES-1:0] hit1, hit2, upd_hit;
   logic               tk0, tk1;
   logic [31:0]        tgt0, tgt1;
   logic               free_found;
   logic [IW-1:0]      free_idx, alloc_idx;

   // Tags are unique (allocation only on miss), so OR-reducing hit targets is exact.
   always_comb begin
      hit1    = '0;
      hit2    = '0;
      upd_hit = '0;
      tk0     = 1'b0;
      tk1     = 1'b0;
      tgt0    = '0;
      tgt1    = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         hit1[i]    = valid_q[i] && (tag_q[i] == current_pc1);
         hit2[i]    = valid_q[i] && (tag_q[i] == current_pc2);
         upd_hit[i] = valid_q[i] && (tag_q[i] == upd_pc);
         if (hit1[i] && cnt_q[i][1]) begin
            tk0  = 1'b1;
            tgt0 = tgt0 | target_q[i];
         end
         if (hit2[i] && cnt_q[i][1]) begin
            tk1  = 1'b1;
            tgt1 = tgt1 | target_q[i];
         end
      end
   end

   assign next_inst_invalid = tk0;
   assign hit_any           = (|hit1) | (|hit2);
   assign bp_bus            = {tk0 | tk1, tk0 ? tgt0 : (tk1 ? tgt1 : 32'h0)};

   always_comb begin
      valid_d    = valid_q;
      tag_d      = tag_q;
      target_d   = target_q;
      cnt_d      = cnt_q;
      rr_d       = rr_q;
      free_found = 1'b0;
      free_idx   = '0;
      alloc_idx  = '0;
      // Scan downward so the last match left standing is the lowest free index.
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
      end
      if (flush_all) begin
         valid_d = '0;
      end else if (upd_valid) begin
         if (|upd_hit) begin
            for (int i = 0; i < ENTRIES; i++) begin
               if (upd_hit[i]) begin
                  if (upd_taken) begin
                     if (cnt_q[i] != 2'b11) cnt_d[i] = cnt_q[i] + 2'd1;
                     target_d[i] = upd_target;
                  end else if (cnt_q[i] != 2'b00) begin
                     cnt_d[i] = cnt_q[i] - 2'd1;
                  end
               end
            end
         end else if (upd_taken) begin
            alloc_idx           = free_found ? free_idx : rr_q;
            valid_d[alloc_idx]  = 1'b1;
            tag_d[alloc_idx]    = upd_pc;
            target_d[alloc_idx] = upd_target;
            cnt_d[alloc_idx]    = CNT_INIT;
            if (!free_found) rr_d = rr_q + IW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q <= '0;
         rr_q    <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
      end else begin
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
         rr_q     <= rr_d;
      end
   end

endmodule

// File: tb/tb_bpu_btb.sv
// Self-checking bench for bpu_btb: directed scenarios plus random traffic
// compared against a table-based reference model of the BTB.
`timescale 1ns/1ps
module tb_bpu_btb;

   localparam int N = 8;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] pc1, pc2, upc, utgt;
   logic        uv, utk, flush;
   logic [32:0] bus;
   logic        nii, hany;

   int n_checks = 0;
   int n_err    = 0;

   logic        m_v   [N];
   logic [31:0] m_tag [N];
   logic [31:0] m_tgt [N];
   int          m_cnt [N];
   int          m_rr;

   bpu_btb #(.ENTRIES(N), .CNT_INIT(2'b10)) dut (
      .clk(clk), .resetn(resetn),
      .current_pc1(pc1), .current_pc2(pc2),
      .upd_valid(uv), .upd_pc(upc), .upd_taken(utk), .upd_target(utgt),
      .flush_all(flush),
      .bp_bus(bus), .next_inst_invalid(nii), .hit_any(hany)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < N; i++) begin
         m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = 0;
      end
      m_rr = 0;
   endfunction

   function automatic void m_look(input logic [31:0] pc, output logic h, output logic t,
                                  output logic [31:0] g);
      h = 1'b0; t = 1'b0; g = '0;
      for (int i = 0; i < N; i++)
         if (m_v[i] && m_tag[i] == pc) begin
            h = 1'b1; t = (m_cnt[i] >= 2); g = m_tgt[i];
         end
   endfunction

   function automatic void m_update();
      int hit_idx = -1;
      int free_idx = -1;
      int slot;
      if (flush) begin
         for (int i = 0; i < N; i++) m_v[i] = 1'b0;
         return;
      end
      if (!uv) return;
      for (int i = 0; i < N; i++) if (m_v[i] && m_tag[i] == upc) hit_idx = i;
      if (hit_idx >= 0) begin
         if (utk) begin
            m_cnt[hit_idx] = (m_cnt[hit_idx] == 3) ? 3 : m_cnt[hit_idx] + 1;
            m_tgt[hit_idx] = utgt;
         end else begin
            m_cnt[hit_idx] = (m_cnt[hit_idx] == 0) ? 0 : m_cnt[hit_idx] - 1;
         end
      end else if (utk) begin
         for (int i = N - 1; i >= 0; i--) if (!m_v[i]) free_idx = i;
         if (free_idx >= 0) slot = free_idx;
         else begin
            slot = m_rr;
            m_rr = (m_rr + 1) % N;
         end
         m_v[slot] = 1'b1; m_tag[slot] = upc; m_tgt[slot] = utgt; m_cnt[slot] = 2;
      end
   endfunction

   task automatic check_outs(input string tag);
      logic h0, t0, h1, t1;
      logic [31:0] g0, g1;
      logic [32:0] eb;
      m_look(pc1, h0, t0, g0);
      m_look(pc2, h1, t1, g1);
      eb = t0 ? {1'b1, g0} : (t1 ? {1'b1, g1} : 33'h0);
      check({tag, "_bus"}, {31'h0, bus}, {31'h0, eb});
      check({tag, "_nii"}, {63'h0, nii}, {63'h0, t0});
      check({tag, "_hit"}, {63'h0, hany}, {63'h0, h0 | h1});
   endtask

   // Called just after a negedge: drive, check current lookup, clock, advance model.
   task automatic step(input string tag, input logic f, input logic v, input logic [31:0] p,
                       input logic t, input logic [31:0] g, input logic [31:0] a,
                       input logic [31:0] b);
      flush = f; uv = v; upc = p; utk = t; utgt = g; pc1 = a; pc2 = b;
      #1;
      check_outs(tag);
      @(posedge clk);
      if (resetn) m_update();
      @(negedge clk);
   endtask

   task automatic alloc(input logic [31:0] p, input logic [31:0] g);
      step("alloc", 1'b0, 1'b1, p, 1'b1, g, 32'hFFFF_FFF0, 32'hFFFF_FFF4);
   endtask

   task automatic look(input string tag, input logic [31:0] a, input logic [31:0] b);
      step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, a, b);
   endtask

   initial begin
      resetn = 1'b0;
      flush = 0; uv = 0; upc = 0; utk = 0; utgt = 0; pc1 = 0; pc2 = 0;
      m_reset();
      @(negedge clk); @(negedge clk);
      #1;
      check("rst_bus", {31'h0, bus}, 64'h0);
      check("rst_nii", {63'h0, nii}, 64'h0);
      check("rst_hit", {63'h0, hany}, 64'h0);
      @(negedge clk);
      resetn = 1'b1;

      // First allocation, visible next cycle only
      step("alloc_same_cycle", 1'b0, 1'b1, 32'h1000, 1'b1, 32'h2000, 32'h1000, 32'h0);
      pc1 = 32'h1000; pc2 = 32'h0; #1;
      check("first_bus", {31'h0, bus}, {31'h0, 1'b1, 32'h2000});
      check("first_nii", {63'h0, nii}, 64'h1);
      check("first_hit", {63'h0, hany}, 64'h1);
      look("first", 32'h1000, 32'h0);

      // Two not-taken updates: counter 10 -> 01 -> 00, entry stays valid
      step("nt1", 1'b0, 1'b1, 32'h1000, 1'b0, 32'h9999, 32'h0, 32'h1000);
      step("nt2", 1'b0, 1'b1, 32'h1000, 1'b0, 32'h9999, 32'h0, 32'h1000);
      pc1 = 32'h0; pc2 = 32'h1000; #1;
      check("cnt0_bpe", {63'h0, bus[32]}, 64'h0);
      check("cnt0_hit", {63'h0, hany}, 64'h1);
      check("cnt0_nii", {63'h0, nii}, 64'h0);
      look("cnt0", 32'h0, 32'h1000);
      step("flush_a", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h1000, 32'h0);

      // Slot-0 priority over slot-1
      alloc(32'h3000, 32'hA0);
      alloc(32'h3004, 32'hB0);
      alloc(32'h3000, 32'hA0);
      alloc(32'h3004, 32'hB0);
      pc1 = 32'h3000; pc2 = 32'h3004; #1;
      check("prio_tgt", {32'h0, bus[31:0]}, 64'hA0);
      check("prio_nii", {63'h0, nii}, 64'h1);
      step("nt_a", 1'b0, 1'b1, 32'h3000, 1'b0, 32'h0, 32'h3000, 32'h3004);
      step("nt_b", 1'b0, 1'b1, 32'h3000, 1'b0, 32'h0, 32'h3000, 32'h3004);
      pc1 = 32'h3000; pc2 = 32'h3004; #1;
      check("slot1_tgt", {31'h0, bus}, {31'h0, 1'b1, 32'hB0});
      check("slot1_nii", {63'h0, nii}, 64'h0);
      step("flush_b", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);

      // Round-robin replacement once the table is full
      for (int k = 1; k <= 9; k++) alloc(32'(k) << 8, 32'h5000 + 32'(k));
      look("rr9", 32'h100, 32'h900);
      pc1 = 32'h100; pc2 = 32'h100; #1;
      check("rr9_evict", {63'h0, hany}, 64'h0);
      pc1 = 32'h200; #1;
      check("rr9_keep", {63'h0, hany}, 64'h1);
      for (int k = 10; k <= 17; k++) alloc(32'(k) << 8, 32'h6000 + 32'(k));
      pc1 = 32'h900; pc2 = 32'h900; #1;
      check("rr17_evict", {63'h0, hany}, 64'h0);
      pc1 = 32'hA00; pc2 = 32'h1100; #1;
      check("rr17_keep", {63'h0, hany}, 64'h1);
      alloc(32'h1200, 32'h7000);
      pc1 = 32'hA00; pc2 = 32'hA00; #1;
      check("rr_wrap1", {63'h0, hany}, 64'h0);
      look("rr_wrap", 32'hB00, 32'h1200);

      // Flush beats a simultaneous taken update
      step("flush_upd", 1'b1, 1'b1, 32'h5550, 1'b1, 32'h5554, 32'h5550, 32'hB00);
      pc1 = 32'h5550; pc2 = 32'hB00; #1;
      check("flush_upd_hit", {63'h0, hany}, 64'h0);
      look("flush_upd", 32'h5550, 32'h1200);

      // Random traffic over a small PC pool so hits, evictions and saturation all occur
      for (int n = 0; n < 600; n++) begin
         step("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
              32'h4000 + (32'($urandom_range(0, 11)) << 2), ($urandom_range(0, 9) < 6),
              $urandom, 32'h4000 + (32'($urandom_range(0, 11)) << 2),
              32'h4000 + (32'($urandom_range(0, 11)) << 2));
      end

      // Asynchronous reset between edges drops a live prediction
      alloc(32'h7000, 32'h7100);
      pc1 = 32'h7000; pc2 = 32'h0; #1;
      check("pre_arst_bus", {31'h0, bus}, {31'h0, 1'b1, 32'h7100});
      #1 resetn = 1'b0;
      #1;
      check("arst_bus", {31'h0, bus}, 64'h0);
      check("arst_hit", {63'h0, hany}, 64'h0);
      m_reset();
      @(negedge clk);
      resetn = 1'b1;

      // Reset landing on a pending update leaves nothing behind
      flush = 0; uv = 1; upc = 32'h8000; utk = 1; utgt = 32'h8100; pc1 = 32'h8000;
      #2 resetn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      uv = 0;
      resetn = 1'b1;
      #1;
      check("rst_mid_upd", {63'h0, hany}, 64'h0);
      look("post_rst", 32'h8000, 32'h7000);
      alloc(32'h8000, 32'h8200);
      look("post_rst_alloc", 32'h8000, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/bpu_btb.md
BPU_BTB -- requirements
Module: bpu_btb

Interface
REQ-001 Parameter ENTRIES, default 8, number of fully-associative BTB entries; SHALL be a power of two in 2..32.
REQ-002 Parameter CNT_INIT, default 2'b10, 2-bit counter value loaded on allocation.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 current_pc1  input  32  fetch-slot-0 lookup PC.
REQ-006 current_pc2  input  32  fetch-slot-1 lookup PC.
REQ-007 upd_valid  input  1  branch-resolution update strobe from execute.
REQ-008 upd_pc  input  32  delay-slot PC of the resolved branch, used as the tag.
REQ-009 upd_taken  input  1  resolved direction; 1 = taken.
REQ-010 upd_target  input  32  resolved target.
REQ-011 flush_all  input  1  synchronous invalidate of every entry.
REQ-012 bp_bus  output  33  {bp_e, bp_target}: prediction valid, predicted target.
REQ-013 next_inst_invalid  output  1  slot-1 instruction SHALL be dropped: slot-0 predicted taken.
REQ-014 hit_any  output  1  either lookup PC matches a valid entry, taken or not.

Function
REQ-015 Each entry SHALL hold valid, tag[31:0], target[31:0] and cnt[1:0].
REQ-016 Lookup SHALL be combinational; hitN[i] = valid[i] & (tag[i] == current_pcN).
REQ-017 A slot SHALL predict taken when it hits an entry with cnt[1] = 1.
REQ-018 If slot 0 predicts taken, bp_e = 1 and bp_target = that entry's target; else if slot 1 predicts taken, bp_e = 1 with slot-1 target; else bp_e = 0 and bp_target = 32'h0.
REQ-019 next_inst_invalid SHALL equal the slot-0 predicted-taken signal only.
REQ-020 Update hit: when upd_valid and upd_pc matches a valid entry, cnt SHALL increment, saturating at 3, if upd_taken; otherwise it SHALL decrement, saturating at 0.
REQ-021 Update hit: target SHALL be overwritten with upd_target only when upd_taken; the entry SHALL stay valid at cnt = 0.
REQ-022 Update miss, not taken: no state SHALL change.
REQ-023 Update miss, taken: the BTB SHALL allocate the lowest-index invalid entry.
REQ-024 Update miss, taken, no entry invalid: the BTB SHALL allocate entry rr_ptr, and rr_ptr SHALL then increment modulo ENTRIES, wrapping from ENTRIES-1 to 0.
REQ-025 Allocation SHALL write valid = 1, tag = upd_pc, target = upd_target, cnt = CNT_INIT.
REQ-026 rr_ptr SHALL advance only on an allocation that replaces a valid entry.
REQ-027 Allocation only on miss SHALL guarantee at most one valid entry per tag; the implementation SHALL rely on this and need no multi-hit priority.
REQ-028 Updates SHALL become visible to lookup on the cycle after the edge; same-cycle lookup SHALL see old state, with no bypass.
REQ-029 flush_all SHALL clear all valid bits at the next edge and take priority over a simultaneous upd_valid, which SHALL be discarded; rr_ptr SHALL be unchanged.
REQ-030 Lookup SHALL never modify state; this differs from the previous generation, where a hit touched the LRU.

Reset
REQ-031 While resetn = 0, all valid, tag, target and cnt SHALL be 0 and rr_ptr SHALL be 0, asynchronously.
REQ-032 In reset, bp_bus = 33'h0, next_inst_invalid = 0 and hit_any = 0.
REQ-033 Reset asserted mid-update SHALL win: no partial entry write survives.
REQ-034 Deassertion SHALL be synchronised externally; the first edge after deassertion SHALL process inputs normally.

Verification
REQ-035 Reset, then upd_valid, upd_pc = 0x1000, taken, target 0x2000 -> next cycle current_pc1 = 0x1000 gives bp_bus = {1, 0x2000}, next_inst_invalid = 1, hit_any = 1.
REQ-036 Same entry, two not-taken updates -> cnt goes 10 -> 01 -> 00; current_pc2 = 0x1000 gives bp_e = 0, hit_any = 1, next_inst_invalid = 0.
REQ-037 ENTRIES = 8: allocate 9 distinct taken PCs 0x100..0x900 -> the ninth replaces entry 0 (PC 0x100 misses) and rr_ptr = 1; allocate 8 more -> rr_ptr wraps to 1 again.
REQ-038 Slot 0 hits target 0xA0, slot 1 hits target 0xB0, both cnt = 3 -> bp_target = 0xA0, next_inst_invalid = 1; slot-0 entry at cnt = 1 -> bp_target = 0xB0, next_inst_invalid = 0.
REQ-039 flush_all and taken upd_valid in the same cycle -> all lookups miss next cycle, and no entry is allocated.
REQ-040 resetn pulled low asynchronously between edges with a valid hit -> bp_bus drops to 0 before the next edge.
